// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the memory-stage load/store unit: access-size
// encodings, FSM states and the alignment rule used by the error check.
package load_store_unit_pkg;

    // Access size as carried on req_size.
    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    // Unit sequencing: one request in flight at a time.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WRITE  = 2'b10,
        RESP   = 2'b11
    } state_e;

    // True when the low address bits do not match the natural alignment
    // of the access size. Illegal sizes are handled separately.
    function automatic logic misaligned(input size_e size, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_mem_lane_align.sv
// Combinational lane steering between a 32-bit memory word and the
// right-aligned register-side data: load extraction with sign/zero
// extension, and store merging of a byte/half into an existing word.
module mem_lane_align
    import load_store_unit_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  lane,
    input  logic        load_signed,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_data
);

    logic [4:0]  byte_shamt;
    logic [4:0]  half_shamt;
    logic [31:0] byte_shifted;
    logic [31:0] half_shifted;

    assign byte_shamt   = {lane, 3'b000};
    assign half_shamt   = {lane[1], 4'b0000};
    assign byte_shifted = rdata >> byte_shamt;
    assign half_shifted = rdata >> half_shamt;

    // Select the addressed lane for loads and splice the store lane into
    // the current word for read-modify-write stores.
    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        load_data   = rdata;
        merged_data = wdata;
        case (size)
            SZ_BYTE: begin
                load_data   = {{24{load_signed & byte_shifted[7]}}, byte_shifted[7:0]};
                merged_data = (rdata & ~(32'h0000_00FF << byte_shamt))
                            | ({24'h0, wdata[7:0]} << byte_shamt);
            end
            SZ_HALF: begin
                load_data   = {{16{load_signed & half_shifted[15]}}, half_shifted[15:0]};
                merged_data = (rdata & ~(32'h0000_FFFF << half_shamt))
                            | ({16'h0, wdata[15:0]} << half_shamt);
            end
            default: begin
                load_data   = rdata;
                merged_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit. Accepts one byte-addressed request at a
// time, rejects bad accesses without touching memory, performs loads with
// lane extraction and sub-word stores as read-modify-write over a single
// combinational-read / write-enable memory port.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_AW    = 15,
    parameter int MEM_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_e      state;
    size_e       req_sz;
    size_e       cap_size;
    logic        cap_we;
    logic        cap_signed;
    logic [1:0]  cap_lane;
    logic [31:0] cap_wdata;

    logic [MEM_AW-1:0] req_word;
    logic [31:0]       req_word_idx;
    logic              high_bits_err;
    logic              range_err;
    logic              access_err;
    logic              req_word_store;
    logic              cap_word_store;

    logic [31:0] load_data;
    logic [31:0] merged_data;

    assign req_sz         = size_e'(req_size);
    assign req_word       = req_addr[MEM_AW+1:2];
    assign req_word_idx   = 32'(req_word);
    assign high_bits_err  = |req_addr[31:MEM_AW+2];
    assign range_err      = (req_word_idx >= 32'(MEM_WORDS));
    assign access_err     = (req_sz == SZ_ILLEGAL)
                          | misaligned(req_sz, req_addr[1:0])
                          | high_bits_err
                          | range_err;
    assign req_word_store = req_we && (req_sz == SZ_WORD);
    assign cap_word_store = cap_we && (cap_size == SZ_WORD);

    // Ready and write enable are pure decodes of registered state, so they
    // are glitch-free and fall as soon as the asynchronous reset hits.
    assign req_ready = (state == IDLE);
    assign mem_we    = (state == WRITE) || ((state == ACCESS) && cap_word_store);

    mem_lane_align u_align (
        .size        (cap_size),
        .lane        (cap_lane),
        .load_signed (cap_signed),
        .rdata       (mem_rdata),
        .wdata       (cap_wdata),
        .load_data   (load_data),
        .merged_data (merged_data)
    );

    // Sequencer: request capture, error routing, memory access and the
    // registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cap_size   <= SZ_BYTE;
            cap_we     <= 1'b0;
            cap_signed <= 1'b0;
            cap_lane   <= 2'b00;
            cap_wdata  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_size   <= req_sz;
                        cap_we     <= req_we;
                        cap_signed <= req_signed;
                        cap_lane   <= req_addr[1:0];
                        cap_wdata  <= req_wdata;
                        if (access_err) begin
                            // Rejected: respond next cycle, memory untouched.
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else begin
                            mem_addr <= req_word;
                            if (req_word_store) begin
                                mem_wdata <= req_wdata;
                            end
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!cap_we) begin
                        resp_rdata <= load_data;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        state      <= RESP;
                    end else if (cap_word_store) begin
                        // Write enable is high during this cycle.
                        resp_rdata <= '0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        state      <= RESP;
                    end else begin
                        // Read half of the read-modify-write.
                        mem_wdata <= merged_data;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    resp_rdata <= '0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    state      <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit. A word-array memory model and a
// request-level reference model predict every response, write strobe and
// memory word; one compare process checks the DUT against them each cycle.
module tb_load_store_unit;

    localparam int MEM_AW    = 15;
    localparam int MEM_WORDS = 256;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0] ram       [0:MEM_WORDS-1];
    logic [31:0] model_mem [0:MEM_WORDS-1];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int accept_cnt = 0;

    // Expectations shared with the compare process.
    int          exp_acc_cyc  = -1;
    int          exp_resp_cyc = -1;
    int          exp_we_cyc   = -1;
    logic        exp_err      = 1'b0;
    logic [31:0] exp_rdata    = '0;
    logic [31:0] hold_rdata   = '0;
    logic        checking     = 1'b0;

    load_store_unit #(.MEM_AW(MEM_AW), .MEM_WORDS(MEM_WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memory: combinational read, write on the rising edge.
    assign mem_rdata = (mem_addr < 15'(MEM_WORDS)) ? ram[mem_addr[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_we && (mem_addr < 15'(MEM_WORDS))) ram[mem_addr[7:0]] <= mem_wdata;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && req_valid && req_ready) accept_cnt <= accept_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model of one request: error rules, lane extraction and
    // memory update, plus latency to response and to the write strobe.
    task automatic model_req(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic err, output logic [31:0] rdata,
                             output int lat, output int we_off);
        logic [31:0] idx;
        logic [31:0] word;
        logic [7:0]  b;
        logic [15:0] h;
        int          lane;
        idx    = addr >> 2;
        lane   = int'(addr[1:0]);
        err    = (size == 2'b11) || (size == 2'b01 && addr[0])
              || (size == 2'b10 && addr[1:0] != 2'b00) || (idx >= 32'(MEM_WORDS));
        rdata  = '0;
        we_off = -1;
        lat    = 2;
        if (err) begin
            lat = 1;
        end else begin
            word = model_mem[idx[7:0]];
            if (!we) begin
                if (size == 2'b00) begin
                    b     = word[8*lane +: 8];
                    rdata = sgn ? 32'($signed(b)) : 32'(b);
                end else if (size == 2'b01) begin
                    h     = word[8*lane +: 16];
                    rdata = sgn ? 32'($signed(h)) : 32'(h);
                end else begin
                    rdata = word;
                end
            end else begin
                if (size == 2'b00)      word[8*lane +: 8]  = wdata[7:0];
                else if (size == 2'b01) word[8*lane +: 16] = wdata[15:0];
                else                    word = wdata;
                model_mem[idx[7:0]] = word;
                lat    = (size == 2'b10) ? 2 : 3;
                we_off = (size == 2'b10) ? 1 : 2;
            end
        end
    endtask

    // Issue one request (called at a falling edge) and wait for it to finish.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] pin_rdata, input logic pin_err);
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          we_off;
        int          budget;
        logic [31:0] idx;
        model_req(we, size, sgn, addr, wdata, err, rdata, lat, we_off);
        check("model_err_pin", 32'(err), 32'(pin_err));
        check("model_rdata_pin", rdata, pin_rdata);
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        budget     = 20;
        while (!req_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("accept_timeout", 32'(req_ready), 32'd1);
        exp_rdata    = rdata;
        exp_err      = err;
        exp_acc_cyc  = cyc;
        exp_resp_cyc = cyc + lat;
        exp_we_cyc   = (we && !err) ? cyc + we_off : -1;
        @(negedge clk);
        req_valid = 1'b0;
        budget    = 20;
        while (cyc <= exp_resp_cyc && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        idx = addr >> 2;
        if (idx < 32'(MEM_WORDS)) check("mem_word", ram[idx[7:0]], model_mem[idx[7:0]]);
    endtask

    // Per-cycle comparison against the expectations of the current request.
    always @(negedge clk) begin
        if (checking) begin
            check("resp_valid", 32'(resp_valid), 32'(cyc == exp_resp_cyc));
            check("mem_we", 32'(mem_we), 32'(cyc == exp_we_cyc));
            check("req_ready", 32'(req_ready), 32'(!(cyc > exp_acc_cyc && cyc <= exp_resp_cyc)));
            if (cyc == exp_resp_cyc) begin
                check("resp_err", 32'(resp_err), 32'(exp_err));
                hold_rdata = exp_rdata;
            end
            check("resp_rdata", resp_rdata, hold_rdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc0;
        int budget;
        int bad;
        for (int i = 0; i < MEM_WORDS; i++) begin
            ram[i]       = 32'(i);
            model_mem[i] = 32'(i);
        end
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (3) @(negedge clk);

        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        reset    = 1'b0;
        checking = 1'b1;
        @(negedge clk);

        //     we    size  sgn   addr          wdata         expected      err
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'h0000_0004, 1'b0);
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'h0000_00AB, 32'h0,        1'b0);
        check("sb_word8", ram[8], 32'h0000_AB08);
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0021, 32'h0,        32'hFFFF_FFAB, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0021, 32'h0,        32'h0000_00AB, 1'b0);
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_1234, 32'h0,        1'b0);
        check("sh_word8", ram[8], 32'h1234_AB08);
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0,        32'h0000_1234, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,        32'h1234_AB08, 1'b0);
        // Rejected accesses.
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0,        32'h0,        1'b1);
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0021, 32'h0,        32'h0,        1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0,        32'h0,        1'b1);
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,        32'h0,        1'b1);
        issue(1'b1, 2'b10, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0,        1'b1);
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0401, 32'h0000_0077, 32'h0,        1'b1);
        // Last implemented word: store, then extract each lane shape.
        issue(1'b0, 2'b10, 1'b0, 32'h0000_03FC, 32'h0,        32'h0000_00FF, 1'b0);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_03FC, 32'h8001_8000, 32'h0,        1'b0);
        issue(1'b0, 2'b01, 1'b1, 32'h0000_03FC, 32'h0,        32'hFFFF_8000, 1'b0);
        issue(1'b0, 2'b01, 1'b0, 32'h0000_03FE, 32'h0,        32'h0000_8001, 1'b0);
        issue(1'b0, 2'b00, 1'b1, 32'h0000_03FF, 32'h0,        32'hFFFF_FF80, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_03FD, 32'h0,        32'h0000_0080, 1'b0);
        check("sw_word255", ram[255], 32'h8001_8000);

        // Store with req_valid held, reset asserted during the write cycle.
        checking   = 1'b0;
        acc0       = accept_cnt;
        req_we     = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0000_0030;
        req_wdata  = 32'h0000_0055;
        req_valid  = 1'b1;
        budget     = 20;
        while (!req_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("hold_accept_timeout", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("hold_we_access", 32'(mem_we), 32'd0);
        @(negedge clk);
        check("hold_we_write", 32'(mem_we), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_we_async", 32'(mem_we), 32'd0);
        check("rst_valid_async", 32'(resp_valid), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_valid", 32'(resp_valid), 32'd0);
        check("post_rst_word12", ram[12], 32'h0000_000C);
        check("single_accept", 32'(accept_cnt - acc0), 32'd1);
        exp_acc_cyc  = -1;
        exp_resp_cyc = -1;
        exp_we_cyc   = -1;
        hold_rdata   = '0;
        checking     = 1'b1;
        @(negedge clk);

        issue(1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0,        32'h0000_000C, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,        32'h1234_AB08, 1'b0);

        bad = 0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            if (ram[i] !== model_mem[i]) bad++;
        end
        check("final_mem_image_bad_words", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
